piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 111 +++++++++++
 tb/tb_piso_serializer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with a one-word holding buffer.
// A word is captured into hold, moved into the shift register, and sent
// one bit per cycle. A second word can wait in hold, so consecutive words
// leave with no idle cycle between them. While idle the serial line rests
// at 0, which a downstream pattern detector sees as a run of zeros.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             out_bit;
    logic [WIDTH-1:0] sh_shift;

    // Handshake: hold can take a word only when empty and not in reset.
    assign data_ready = !hold_full_q && !rst;
    assign accept     = data_valid && data_ready;

    // Output end of the shift register and the one-step shift toward it.
    assign out_bit  = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
    assign sh_shift = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sh_q[WIDTH-1:1]};

    // Serial outputs are decoded from state and forced low during reset.
    assign ser_valid = (state_q == ST_SHIFT) && !rst;
    assign ser_out   = ser_valid && out_bit;
    assign word_done = ser_valid && (cnt_q == CNT_LAST);

    // Next-state logic for the FSM, hold buffer, shifter and bit counter.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d     = ST_SHIFT;
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    sh_d  = sh_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (hold_full_q) begin
                    // Last bit out and a word is waiting: reload with no gap.
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept only happens with hold empty, so it never collides with a drain.
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset that overrides all activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a cycle table for a single word, a bit
// scoreboard for streamed words, and hand sequences for reset, back-pressure,
// LSB-first ordering and a 1001 pattern detector on the serial line.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, a_ser_out, a_ser_valid, a_word_done;
    logic       b_ready, b_ser_out, b_ser_valid, b_word_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (a_data),
        .data_valid (a_valid),
        .data_ready (a_ready),
        .ser_out    (a_ser_out),
        .ser_valid  (a_ser_valid),
        .word_done  (a_word_done)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (b_data),
        .data_valid (b_valid),
        .data_ready (b_ready),
        .ser_out    (b_ser_out),
        .ser_valid  (b_ser_valid),
        .word_done  (b_word_done)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected serial bits for the MSB-first instance.
    typedef struct packed {
        logic b;
        logic d;
    } sb_t;
    sb_t sb_q[$];
    logic sb_en = 1'b0;
    logic streaming = 1'b0;

    task automatic push_word(input logic [7:0] w);
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = w[7-i];
            e.d = (i == 7);
            sb_q.push_back(e);
        end
    endtask

    // Compare every serial bit against the scoreboard; flag gaps mid-stream.
    always @(negedge clk) begin
        sb_t e;
        if (sb_en) begin
            if (a_ser_valid) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_unexpected_bit: got ser_valid=1 expected no bit at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk1("sb_ser_out", a_ser_out, e.b);
                    chk1("sb_word_done", a_word_done, e.d);
                    streaming = 1'b1;
                end
            end else if (streaming) begin
                chk1("sb_no_gap", a_ser_valid, 1'b1);
                streaming = 1'b0;
            end
            if (sb_q.size() == 0) streaming = 1'b0;
        end
    end

    // Reference 1001 overlapping detector fed by the serial line.
    logic [3:0] det_sh = 4'b0000;
    int         det_cnt = 0;
    always @(posedge clk) begin
        if ({det_sh[2:0], a_ser_out} == 4'b1001) det_cnt <= det_cnt + 1;
        det_sh <= {det_sh[2:0], a_ser_out};
    end

    task automatic send_a(input logic [7:0] w);
        int n = 0;
        a_valid = 1'b1;
        a_data  = w;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got data_ready=0 expected 1 within 50 cycles");
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            push_word(w);
            #1;
        end
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d bits pending expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       e_ready;
        logic       e_sv;
        logic       e_so;
        logic       e_wd;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic [7:0] w;
        int c0;

        // Single 8'h90 word, cycle by cycle; step 2 offers FF while hold is full.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 8'h00;
        b_valid = 1'b0;
        b_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            rst     = tbl[i].rst;
            a_valid = tbl[i].valid;
            a_data  = tbl[i].data;
            @(negedge clk);
            chk1($sformatf("tbl%0d_ready", i), a_ready, tbl[i].e_ready);
            chk1($sformatf("tbl%0d_ser_valid", i), a_ser_valid, tbl[i].e_sv);
            chk1($sformatf("tbl%0d_ser_out", i), a_ser_out, tbl[i].e_so);
            chk1($sformatf("tbl%0d_word_done", i), a_word_done, tbl[i].e_wd);
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;

        // Two words, second accepted while the first shifts: 16 bits, no gap.
        sb_en = 1'b1;
        send_a(8'hA5);
        send_a(8'h3C);
        drain();

        // Valid held high across three words; track data_ready around reloads.
        a_valid = 1'b1;
        a_data  = 8'hA5;
        @(negedge clk);
        chk1("bp_ready_first", a_ready, 1'b1);
        @(posedge clk);
        push_word(8'hA5);
        #1;
        a_data = 8'h3C;
        @(negedge clk);
        chk1("bp_ready_hold_full", a_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("bp_ready_after_load", a_ready, 1'b1);
        @(posedge clk);
        push_word(8'h3C);
        #1;
        a_data = 8'h5A;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk1($sformatf("bp_ready_blocked%0d", k), a_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk1("bp_ready_after_reload", a_ready, 1'b1);
        @(posedge clk);
        push_word(8'h5A);
        #1;
        a_valid = 1'b0;
        drain();

        // 8'h99 on the serial line holds two 1001 patterns.
        repeat (5) @(posedge clk);
        #1;
        c0 = det_cnt;
        send_a(8'h99);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk_int("detector_pulses", det_cnt - c0, 2);
        sb_en = 1'b0;

        // Reset on the third bit of FF with 00 waiting in hold.
        a_valid = 1'b1;
        a_data  = 8'hFF;
        @(posedge clk);
        #1;
        a_data = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_mid_ser_valid", a_ser_valid, 1'b0);
        chk1("rst_mid_ser_out", a_ser_out, 1'b0);
        chk1("rst_mid_ready", a_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_after_ser_valid", a_ser_valid, 1'b0);
        chk1("rst_after_ser_out", a_ser_out, 1'b0);
        chk1("rst_after_ready", a_ready, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk1($sformatf("rst_no_resume%0d", k), a_ser_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // LSB-first instance with 8'h09.
        w       = 8'h09;
        b_valid = 1'b1;
        b_data  = w;
        @(negedge clk);
        chk1("lsb_ready", b_ready, 1'b1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1($sformatf("lsb_ser_valid%0d", i), b_ser_valid, 1'b1);
            chk1($sformatf("lsb_ser_out%0d", i), b_ser_out, w[i]);
            chk1($sformatf("lsb_word_done%0d", i), b_word_done, i == 7);
        end
        @(negedge clk);
        chk1("lsb_idle_after", b_ser_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
